onehot_encode: RTL and testbench
================================

// Module: onehot_encode
// PURPOSE
//  Converts a 10-bit one-hot digit vector (bit i hot = digit i+1, range 1..10) back to 4-bit binary.
//  Checks input legality: zero-hot and multi-hot vectors are flagged and counted.
//  Valid/ready on both sides; 2-entry skid buffer gives full throughput with registered IN_READY.
//  Sits between the watch one-hot digit state and the binary display/compare path.
// PARAMETERS
//  ERR_CNT_W  8  width of the saturating illegal-input counter ERR_COUNT
// PORTS
//  CLK        in   1          single clock, rising edge
//  RESET_N    in   1          asynchronous active-low reset
//  IN_VALID   in   1          ONE_HOT is valid this cycle
//  IN_READY   out  1          block accepts input; transfer = IN_VALID & IN_READY
//  ONE_HOT    in   10         one-hot digit, bit0 = 1 ... bit9 = 10
//  OUT_VALID  out  1          BINARY/ERR valid
//  OUT_READY  in   1          sink accepts; transfer = OUT_VALID & OUT_READY
//  BINARY     out  4          encoded digit, 4'b0001..4'b1010
//  ERR        out  1          this output word came from an illegal input
//  ERR_COUNT  out  ERR_CNT_W  illegal inputs accepted since reset/clear, saturating
//  ERR_CLR    in   1          synchronous clear of ERR_COUNT
// BEHAVIOUR
//  Reset (async, RESET_N=0): IN_READY=0, OUT_VALID=0, BINARY=4'b0001, ERR=0, ERR_COUNT=0, state EMPTY.
//    IN_READY goes 1 on the first CLK edge after reset release.
//  Encode (combinational on accept): exactly one bit i set -> BINARY=i+1, ERR=0.
//    All-zero -> BINARY=4'b0001, ERR=1. Multi-hot -> see CONFIGURATION, ERR=1.
//  Buffer FSM, states EMPTY / ONE / TWO (count of held words):
//    EMPTY: accept -> ONE.
//    ONE: accept & !pop -> TWO. pop & !accept -> EMPTY. Both -> ONE, new word queued behind.
//    TWO: no accept (IN_READY=0). pop -> ONE.
//  IN_READY is registered: 1 iff next state != TWO. OUT_VALID = (state != EMPTY).
//  Order is strictly FIFO. Head word stays stable while OUT_VALID & !OUT_READY.
//  Latency: word accepted at edge N is on BINARY/OUT_VALID after edge N, if the buffer was EMPTY.
//  ERR_COUNT increments by 1 on each accepted illegal input and saturates at all-ones.
//    ERR_CLR has priority over an increment in the same cycle; result is 0.
//  IN_VALID with IN_READY=0: no accept, no count.
//  Reset mid-operation: held words are discarded; no partial output.
// CONFIGURATION
//  ONEHOT_PRIORITY_EN defined: multi-hot encodes to the lowest set bit.
//    Example: 10'b0000100100 -> 4'b0011, ERR=1.
//  Not defined: multi-hot encodes to 4'b0001 (default digit), ERR=1.
//  Zero-hot is 4'b0001 in both builds.
// STRUCTURE
//  Shared package: DIGIT_W=4, ONEHOT_W=10, DIGIT_DEFAULT=4'b0001, FSM state encodings
//    (EMPTY/ONE/TWO). Decoder and encoder use the same constants.
//  One sub-module: onehot_encode_core. Combinational encode plus legality check
//    (outputs code, err). Instantiated once at the input.
//  Top level holds the FSM, the two 5-bit entries {ERR,BINARY}, and the counter.
// TESTING
//  1 Sweep bit0..bit9 one at a time, OUT_READY=1 -> BINARY 1..10 in order, ERR=0, one word per cycle.
//  2 ONE_HOT=0 and 10'b1000000001 -> ERR=1, ERR_COUNT=2.
//    BINARY=1,1 without ONEHOT_PRIORITY_EN; 1,1 with it (lowest bit of 10'b1000000001 is bit0).
//    Also 10'b0000001100 -> 4'b0011 (with macro) / 4'b0001 (without).
//  3 OUT_READY=0, stream 3 words -> 2 accepted, IN_READY=0 after 2nd.
//    Release OUT_READY -> words out in order, 3rd accepted, no loss or duplication.
//  4 Force 2^ERR_CNT_W+3 illegal inputs -> ERR_COUNT holds at all-ones.
//    ERR_CLR together with an illegal input -> ERR_COUNT=0.
//  5 Assert RESET_N=0 with state TWO -> OUT_VALID=0 and IN_READY=0 immediately, BINARY=4'b0001.
//    After release: buffer empty, IN_READY=1 after one edge.
//  6 Random IN_VALID/OUT_READY, 10k cycles, scoreboard vs reference model -> zero mismatches.

Source files
------------

// File: rtl/onehot_encode_pkg.sv
// Shared constants, FSM state encodings and buffer entry type for the one-hot to binary encoder.
package onehot_encode_pkg;
  localparam int DIGIT_W  = 4;
  localparam int ONEHOT_W = 10;
  localparam logic [DIGIT_W-1:0] DIGIT_DEFAULT = 4'b0001;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_TWO   = 2'b10;

  typedef struct packed {
    logic               err;
    logic [DIGIT_W-1:0] code;
  } entry_t;

  localparam entry_t ENTRY_RST = '{err: 1'b0, code: DIGIT_DEFAULT};
endpackage

// File: rtl/onehot_encode_core.sv
// Combinational one-hot to binary encode with legality check.
// ONEHOT_PRIORITY_EN: multi-hot encodes to the lowest set bit instead of the default digit.
module onehot_encode_core
  import onehot_encode_pkg::*;
(
  input  logic [ONEHOT_W-1:0] one_hot,
  output logic [DIGIT_W-1:0]  code,
  output logic                err
);
  logic [DIGIT_W-1:0] low_code;
  logic               legal;
  logic               zero;

  // scanning downwards leaves the lowest set bit's digit in low_code
  always_comb begin
    low_code = DIGIT_DEFAULT;
    for (int i = ONEHOT_W-1; i >= 0; i--)
      if (one_hot[i]) low_code = DIGIT_W'(i+1);
  end

  assign legal = $onehot(one_hot);
  assign zero  = ~|one_hot;
  assign err   = ~legal;

  always_comb begin
    code = DIGIT_DEFAULT;
    if (legal)      code = low_code;
    else if (zero)  code = DIGIT_DEFAULT;
    else begin
`ifdef ONEHOT_PRIORITY_EN
      code = low_code;
`else
      code = DIGIT_DEFAULT;
`endif
    end
  end
endmodule

// File: rtl/onehot_encode.sv
// One-hot digit to binary encoder with a 2-entry skid buffer and saturating illegal-input counter.
// Optional build macro: ONEHOT_PRIORITY_EN (handled in onehot_encode_core).
module onehot_encode
  import onehot_encode_pkg::*;
#(
  parameter int ERR_CNT_W = 8
)(
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [ONEHOT_W-1:0]  ONE_HOT,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [DIGIT_W-1:0]   BINARY,
  output logic                 ERR,
  output logic [ERR_CNT_W-1:0] ERR_COUNT,
  input  logic                 ERR_CLR
);
  logic [1:0] state, state_nxt;
  entry_t     head, tail, in_word;
  logic       accept, pop;

  onehot_encode_core u_core (
    .one_hot (ONE_HOT),
    .code    (in_word.code),
    .err     (in_word.err)
  );

  assign accept    = IN_VALID & IN_READY;
  assign OUT_VALID = (state != ST_EMPTY);
  assign pop       = OUT_VALID & OUT_READY;
  assign BINARY    = head.code;
  assign ERR       = head.err;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_ONE;
      ST_ONE:   if (accept & ~pop) state_nxt = ST_TWO;
                else if (pop & ~accept) state_nxt = ST_EMPTY;
      ST_TWO:   if (pop) state_nxt = ST_ONE;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= ST_EMPTY;
      IN_READY <= 1'b0;
      head     <= ENTRY_RST;
      tail     <= ENTRY_RST;
    end else begin
      state    <= state_nxt;
      IN_READY <= (state_nxt != ST_TWO);
      case (state)
        ST_EMPTY: if (accept) head <= in_word;
        ST_ONE: begin
          // with a simultaneous pop the new word replaces the departing head
          if (accept & pop)  head <= in_word;
          else if (accept)   tail <= in_word;
        end
        ST_TWO:   if (pop) head <= tail;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      ERR_COUNT <= '0;
    else if (ERR_CLR)
      ERR_COUNT <= '0;
    else if (accept & in_word.err & ~&ERR_COUNT)
      ERR_COUNT <= ERR_COUNT + ERR_CNT_W'(1);
  end
endmodule

// File: tb/tb_onehot_encode.sv
// Self-checking bench for onehot_encode: directed scenarios plus a randomized scoreboard run.
module tb_onehot_encode;
  localparam int ERR_CNT_W = 8;
  localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;

  logic                 CLK = 1'b0;
  logic                 RESET_N = 1'b0;
  logic                 IN_VALID = 1'b0;
  logic                 IN_READY;
  logic [9:0]           ONE_HOT = '0;
  logic                 OUT_VALID;
  logic                 OUT_READY = 1'b0;
  logic [3:0]           BINARY;
  logic                 ERR;
  logic [ERR_CNT_W-1:0] ERR_COUNT;
  logic                 ERR_CLR = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [4:0] q[$];
  int         cnt_m = 0;
  bit         ready_m = 0;

  onehot_encode #(.ERR_CNT_W(ERR_CNT_W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .ONE_HOT(ONE_HOT), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .BINARY(BINARY), .ERR(ERR), .ERR_COUNT(ERR_COUNT), .ERR_CLR(ERR_CLR)
  );

  always #5 CLK = ~CLK;

  // reference word {err, digit} from the digit rules
  function automatic logic [4:0] ref_word(input logic [9:0] oh);
    int n;
    int low;
    n = $countones(oh);
    low = -1;
    for (int i = 0; i < 10; i++) if (oh[i] && low < 0) low = i;
    if (n == 1) return {1'b0, 4'(low + 1)};
    if (n == 0) return {1'b1, 4'd1};
`ifdef ONEHOT_PRIORITY_EN
    return {1'b1, 4'(low + 1)};
`else
    return {1'b1, 4'd1};
`endif
  endfunction

  // drive one cycle from a negedge, advance the model across the posedge, return at the next negedge
  task automatic drive_cycle(input bit iv, input logic [9:0] oh, input bit ordy, input bit clr);
    logic [4:0] w;
    bit acc, pp;
    IN_VALID = iv; ONE_HOT = oh; OUT_READY = ordy; ERR_CLR = clr;
    w   = ref_word(oh);
    acc = iv && ready_m;
    pp  = (q.size() != 0) && ordy;
    if (pp) void'(q.pop_front());
    if (acc) q.push_back(w);
    if (clr) cnt_m = 0;
    else if (acc && w[4] && cnt_m < CNT_MAX) cnt_m++;
    ready_m = (q.size() < 2);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 1'b0;
    IN_VALID = 0; OUT_READY = 0; ERR_CLR = 0;
    #1;
    q.delete(); cnt_m = 0; ready_m = 0;
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    @(negedge CLK);
    checks++;
    if (IN_READY !== 1'b0 || OUT_VALID !== 1'b0 || BINARY !== 4'd1 || ERR !== 1'b0 || ERR_COUNT !== '0) begin
      failures++;
      $display("FAIL reset_state: rdy=%b vld=%b bin=%0d err=%b cnt=%0d, want 0 0 1 0 0",
               IN_READY, OUT_VALID, BINARY, ERR, ERR_COUNT);
    end
    q.delete(); cnt_m = 0; ready_m = 0;
    RESET_N = 1'b1;
    drive_cycle(0, '0, 0, 0);
    checks++;
    if (IN_READY !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_rise: IN_READY=%b want 1", IN_READY);
    end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1, 10'(1 << i), 1, 0);
      checks++;
      if (OUT_VALID !== 1'b1 || BINARY !== 4'(i + 1) || ERR !== 1'b0 || IN_READY !== 1'b1) begin
        failures++;
        $display("FAIL sweep_bit%0d: vld=%b bin=%0d err=%b rdy=%b, want 1 %0d 0 1",
                 i, OUT_VALID, BINARY, ERR, IN_READY, i + 1);
      end
    end
    drive_cycle(0, '0, 1, 0);
    checks++;
    if (OUT_VALID !== 1'b0) begin
      failures++;
      $display("FAIL sweep_drain: OUT_VALID=%b want 0", OUT_VALID);
    end
  endtask

  task automatic test_illegal();
    logic [9:0] pats [3];
    logic [3:0] want [3];
    pats[0] = 10'b0000000000; want[0] = 4'd1;
    pats[1] = 10'b1000000001; want[1] = 4'd1;
    pats[2] = 10'b0000001100;
`ifdef ONEHOT_PRIORITY_EN
    want[2] = 4'd3;
`else
    want[2] = 4'd1;
`endif
    drive_cycle(0, '0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1, pats[i], 1, 0);
      checks++;
      if (OUT_VALID !== 1'b1 || BINARY !== want[i] || ERR !== 1'b1 || ERR_COUNT !== ERR_CNT_W'(i + 1)) begin
        failures++;
        $display("FAIL illegal_%0d: vld=%b bin=%0d err=%b cnt=%0d, want 1 %0d 1 %0d",
                 i, OUT_VALID, BINARY, ERR, ERR_COUNT, want[i], i + 1);
      end
    end
    drive_cycle(0, '0, 1, 0);
  endtask

  task automatic test_backpressure();
    drive_cycle(1, 10'b0000001000, 0, 0);
    checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b1 || BINARY !== 4'd4) begin
      failures++;
      $display("FAIL bp_first: rdy=%b vld=%b bin=%0d, want 1 1 4", IN_READY, OUT_VALID, BINARY);
    end
    drive_cycle(1, 10'b0001000000, 0, 0);
    checks++;
    if (IN_READY !== 1'b0 || BINARY !== 4'd4) begin
      failures++;
      $display("FAIL bp_full: rdy=%b bin=%0d, want 0 4", IN_READY, BINARY);
    end
    drive_cycle(1, 10'b0100000000, 0, 0);
    checks++;
    if (IN_READY !== 1'b0 || BINARY !== 4'd4 || OUT_VALID !== 1'b1) begin
      failures++;
      $display("FAIL bp_stall: rdy=%b vld=%b bin=%0d, want 0 1 4", IN_READY, OUT_VALID, BINARY);
    end
    drive_cycle(1, 10'b0100000000, 1, 0);
    checks++;
    if (IN_READY !== 1'b1 || BINARY !== 4'd7) begin
      failures++;
      $display("FAIL bp_pop1: rdy=%b bin=%0d, want 1 7", IN_READY, BINARY);
    end
    drive_cycle(1, 10'b0100000000, 1, 0);
    checks++;
    if (OUT_VALID !== 1'b1 || BINARY !== 4'd9) begin
      failures++;
      $display("FAIL bp_pop2: vld=%b bin=%0d, want 1 9", OUT_VALID, BINARY);
    end
    drive_cycle(0, '0, 1, 0);
    checks++;
    if (OUT_VALID !== 1'b0) begin
      failures++;
      $display("FAIL bp_no_dup: OUT_VALID=%b want 0", OUT_VALID);
    end
  endtask

  task automatic test_saturate();
    drive_cycle(0, '0, 1, 1);
    for (int i = 0; i < CNT_MAX + 4; i++) drive_cycle(1, '0, 1, 0);
    checks++;
    if (ERR_COUNT !== ERR_CNT_W'(CNT_MAX)) begin
      failures++;
      $display("FAIL saturate: ERR_COUNT=%0d want %0d", ERR_COUNT, CNT_MAX);
    end
    drive_cycle(1, 10'b0000000011, 1, 1);
    checks++;
    if (ERR_COUNT !== '0) begin
      failures++;
      $display("FAIL clr_priority: ERR_COUNT=%0d want 0", ERR_COUNT);
    end
    drive_cycle(0, '0, 1, 0);
  endtask

  task automatic test_reset_mid();
    drive_cycle(1, 10'b0000000100, 0, 0);
    drive_cycle(1, 10'b0000010000, 0, 0);
    checks++;
    if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1) begin
      failures++;
      $display("FAIL mid_two: rdy=%b vld=%b, want 0 1", IN_READY, OUT_VALID);
    end
    RESET_N = 1'b0;
    #1;
    checks++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b0 || BINARY !== 4'd1) begin
      failures++;
      $display("FAIL mid_reset: vld=%b rdy=%b bin=%0d, want 0 0 1", OUT_VALID, IN_READY, BINARY);
    end
    q.delete(); cnt_m = 0; ready_m = 0;
    @(negedge CLK);
    RESET_N = 1'b1;
    drive_cycle(0, '0, 1, 0);
    checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
      failures++;
      $display("FAIL mid_release: rdy=%b vld=%b, want 1 0", IN_READY, OUT_VALID);
    end
  endtask

  task automatic test_random();
    logic [9:0] oh;
    int sel;
    for (int c = 0; c < 10000; c++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5)      oh = 10'(1 << $urandom_range(0, 9));
      else if (sel < 7) oh = '0;
      else              oh = 10'($urandom);
      drive_cycle($urandom_range(0, 3) != 0, oh, $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
      checks++;
      if (OUT_VALID !== (q.size() != 0) || IN_READY !== ready_m || ERR_COUNT !== ERR_CNT_W'(cnt_m)) begin
        failures++;
        $display("FAIL rand_ctl cyc%0d: vld=%b rdy=%b cnt=%0d, want %b %b %0d",
                 c, OUT_VALID, IN_READY, ERR_COUNT, q.size() != 0, ready_m, cnt_m);
      end
      if (q.size() != 0) begin
        checks++;
        if ({ERR, BINARY} !== q[0]) begin
          failures++;
          $display("FAIL rand_data cyc%0d: err=%b bin=%0d, want err=%b bin=%0d",
                   c, ERR, BINARY, q[0][4], q[0][3:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_illegal();
    test_backpressure();
    test_saturate();
    test_reset_mid();
    do_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
